// File: rtl/addr_seq_gen.sv
// Programmable address sequencer for the ALU datapath: walks from a latched base
// toward a latched limit by a fixed step, either once or repeatedly with wrap counting.
module addr_seq_gen #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              op_done,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_limit,
    input  logic [ADDR_W-1:0] cfg_step,
    input  logic              cfg_down,
    input  logic              cfg_wrap,
    output logic [ADDR_W-1:0] address,
    output logic              valid,
    output logic              last,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  wrap_cnt
);

    // state  | meaning
    // S_IDLE | waiting for start, address holds
    // S_RUN  | address live, advancing on op_done
    // S_DONE | one-cycle completion pulse of a one-shot pass
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] base_q, limit_q, step_q;
    logic              down_q, wrap_q;

    logic [ADDR_W-1:0] addr_d;
    logic [CNT_W-1:0]  wrap_cnt_d;
    logic              load_cfg;

    logic [ADDR_W:0]   step_eff, rem, addr_ext, limit_ext, addr_adv;
    logic              at_last;

    // Distance math is one bit wider so address +/- step never wraps silently.
    assign step_eff  = (step_q == '0) ? {{ADDR_W{1'b0}}, 1'b1} : {1'b0, step_q};
    assign addr_ext  = {1'b0, address};
    assign limit_ext = {1'b0, limit_q};
    assign addr_adv  = down_q ? (addr_ext - step_eff) : (addr_ext + step_eff);

    always_comb begin
        rem = '0;
        if (!down_q) begin
            if (addr_ext <= limit_ext) rem = limit_ext - addr_ext;
        end else begin
            if (addr_ext >= limit_ext) rem = addr_ext - limit_ext;
        end
    end

    assign at_last = (rem < step_eff);

    always_comb begin
        state_d    = state_q;
        addr_d     = address;
        wrap_cnt_d = wrap_cnt;
        load_cfg   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_cfg   = 1'b1;
                    addr_d     = cfg_base;
                    wrap_cnt_d = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (op_done) begin
                    if (!at_last) begin
                        addr_d = addr_adv[ADDR_W-1:0];
                    end else if (wrap_q) begin
                        addr_d = base_q;
                        if (wrap_cnt != {CNT_W{1'b1}})
                            wrap_cnt_d = wrap_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            address  <= '0;
            wrap_cnt <= '0;
            base_q   <= '0;
            limit_q  <= '0;
            step_q   <= '0;
            down_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            address  <= addr_d;
            wrap_cnt <= wrap_cnt_d;
            if (load_cfg) begin
                base_q  <= cfg_base;
                limit_q <= cfg_limit;
                step_q  <= cfg_step;
                down_q  <= cfg_down;
                wrap_q  <= cfg_wrap;
            end
        end
    end

    assign valid = (state_q == S_RUN);
    assign last  = valid && at_last;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_addr_seq_gen.sv
// Self-checking bench for addr_seq_gen: directed scenarios plus randomized traffic,
// compared each cycle against a list-based reference model of the address sequence.
module tb_addr_seq_gen;

    localparam int AW = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, start, abort, op_done, cfg_down, cfg_wrap;
    logic [AW-1:0] cfg_base, cfg_limit, cfg_step;
    logic [AW-1:0] address;
    logic          valid, last, busy, done;
    logic [CW-1:0] wrap_cnt;

    addr_seq_gen #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .op_done(op_done),
        .cfg_base(cfg_base), .cfg_limit(cfg_limit), .cfg_step(cfg_step),
        .cfg_down(cfg_down), .cfg_wrap(cfg_wrap),
        .address(address), .valid(valid), .last(last), .busy(busy), .done(done),
        .wrap_cnt(wrap_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the full address list of a pass is built at start,
    // then the model just walks an index through it.
    int m_state = 0;   // 0 idle, 1 run, 2 done
    int m_seq[$];
    int m_idx   = 0;
    int m_wc    = 0;
    int m_addr  = 0;
    bit m_wrap  = 0;

    task automatic model_edge();
        int s, a, lim;
        if (reset) begin
            m_state = 0; m_idx = 0; m_wc = 0; m_addr = 0; m_wrap = 0;
            m_seq.delete(); m_seq.push_back(0);
        end else begin
            case (m_state)
                0: if (start) begin
                    s   = (cfg_step == 0) ? 1 : int'(cfg_step);
                    a   = int'(cfg_base);
                    lim = int'(cfg_limit);
                    m_seq.delete();
                    m_seq.push_back(a);
                    if (!cfg_down) begin
                        while (a + s <= lim) begin a += s; m_seq.push_back(a); end
                    end else begin
                        while (a - s >= lim) begin a -= s; m_seq.push_back(a); end
                    end
                    m_wrap = cfg_wrap; m_idx = 0; m_addr = m_seq[0]; m_wc = 0; m_state = 1;
                end
                1: if (abort) m_state = 0;
                   else if (op_done) begin
                       if (m_idx < m_seq.size() - 1) begin
                           m_idx++; m_addr = m_seq[m_idx];
                       end else if (m_wrap) begin
                           m_idx = 0; m_addr = m_seq[0];
                           if (m_wc < 255) m_wc++;
                       end else m_state = 2;
                   end
                default: m_state = 0;
            endcase
        end
    endtask

    function automatic logic [AW+4+CW-1:0] exp_vec();
        logic [AW-1:0] a;
        logic v, l, b, d;
        a = AW'(m_addr);
        v = (m_state == 1);
        l = v && (m_idx == m_seq.size() - 1);
        b = (m_state != 0);
        d = (m_state == 2);
        return {a, v, l, b, d, CW'(m_wc)};
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_cfg(input int b, input int l, input int s, input bit d, input bit w);
        cfg_base = AW'(b); cfg_limit = AW'(l); cfg_step = AW'(s); cfg_down = d; cfg_wrap = w;
    endtask

    task automatic test_reset();
        reset = 1; start = 1; op_done = 1; abort = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin reset = 0; start = 0; op_done = 0; end
            cycle();
            n_checks++;
            if ({address, valid, last, busy, done, wrap_cnt} !== {AW'(0), 4'b0000, CW'(0)})
                $display("FAIL reset_idle cyc%0d: got %h want %h", i,
                         {address, valid, last, busy, done, wrap_cnt}, {AW'(0), 4'b0000, CW'(0)});
            else n_pass++;
        end
    endtask

    task automatic test_up_oneshot();
        int obs[$];
        int dones = 0;
        set_cfg(1, 6, 2, 0, 0);
        start = 1;
        cycle();
        start = 0; op_done = 1;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if ({address, valid, last, busy, done, wrap_cnt} !== exp_vec())
                $display("FAIL up_oneshot cyc%0d: got %h want %h", i, {address, valid, last, busy, done, wrap_cnt}, exp_vec());
            else n_pass++;
            if (valid) obs.push_back(int'(address));
            if (done) dones++;
            if (last && address != 3'd5) begin
                n_checks++;
                $display("FAIL up_oneshot_last: got last at %0d want only at 5", address);
            end
            if (i < 5) cycle();
        end
        op_done = 0;
        n_checks++;
        if (obs.size() != 3 || obs[0] != 1 || obs[1] != 3 || obs[2] != 5 || dones != 1 || address != 3'd5 || busy)
            $display("FAIL up_oneshot_seq: got n=%0d dones=%0d addr=%0d busy=%0b want 1,3,5 dones=1 addr=5 busy=0",
                     obs.size(), dones, address, busy);
        else n_pass++;
    endtask

    task automatic test_down_wrap();
        int dones = 0;
        set_cfg(6, 0, 3, 1, 1);
        start = 1;
        cycle();
        start = 0;
        for (int i = 0; i < 12; i++) begin
            op_done = (i % 2 == 0);
            cycle();
            n_checks++;
            if ({address, valid, last, busy, done, wrap_cnt} !== exp_vec())
                $display("FAIL down_wrap cyc%0d: got %h want %h", i, {address, valid, last, busy, done, wrap_cnt}, exp_vec());
            else n_pass++;
            if (done) dones++;
        end
        op_done = 0;
        n_checks++;
        if (address != 3'd6 || wrap_cnt != 8'd2 || dones != 0 || !valid)
            $display("FAIL down_wrap_end: got addr=%0d wc=%0d dones=%0d want addr=6 wc=2 dones=0",
                     address, wrap_cnt, dones);
        else n_pass++;
        abort = 1;
        cycle();
        abort = 0;
    endtask

    task automatic test_step_zero();
        int obs[$];
        int dones = 0;
        bit ok;
        set_cfg(0, 7, 0, 0, 0);
        start = 1;
        cycle();
        start = 0; op_done = 1;
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if ({address, valid, last, busy, done, wrap_cnt} !== exp_vec())
                $display("FAIL step_zero cyc%0d: got %h want %h", i, {address, valid, last, busy, done, wrap_cnt}, exp_vec());
            else n_pass++;
            if (valid) obs.push_back(int'(address));
            if (done) dones++;
            if (i < 10) cycle();
        end
        op_done = 0;
        ok = (obs.size() == 8) && (dones == 1) && (address == 3'd7);
        foreach (obs[k]) if (obs[k] != k) ok = 0;
        n_checks++;
        if (!ok)
            $display("FAIL step_zero_seq: got n=%0d dones=%0d addr=%0d want 0..7 dones=1 addr=7",
                     obs.size(), dones, address);
        else n_pass++;
    endtask

    task automatic test_abort();
        set_cfg(0, 7, 1, 0, 0);
        start = 1;
        cycle();
        start = 0; op_done = 1;
        repeat (3) cycle();
        op_done = 0;
        n_checks++;
        if (address !== 3'd3 || !valid)
            $display("FAIL abort_pre: got addr=%0d valid=%0b want addr=3 valid=1", address, valid);
        else n_pass++;
        abort = 1; op_done = 1;
        cycle();
        abort = 0; op_done = 0;
        n_checks++;
        if ({address, valid, last, busy, done} !== {3'd3, 4'b0000} || {address, valid, last, busy, done, wrap_cnt} !== exp_vec())
            $display("FAIL abort_idle: got %h want %h", {address, valid, last, busy, done, wrap_cnt}, exp_vec());
        else n_pass++;
        set_cfg(2, 7, 1, 0, 0);
        start = 1;
        cycle();
        start = 0;
        n_checks++;
        if (address !== 3'd2 || !valid || !busy)
            $display("FAIL abort_restart: got addr=%0d valid=%0b want addr=2 valid=1", address, valid);
        else n_pass++;
        abort = 1;
        cycle();
        abort = 0;
    endtask

    task automatic test_reset_mid();
        set_cfg(1, 7, 1, 0, 1);
        start = 1;
        cycle();
        start = 0; op_done = 1;
        repeat (2) cycle();
        reset = 1; start = 1; abort = 1;
        cycle();
        n_checks++;
        if ({address, valid, last, busy, done, wrap_cnt} !== {AW'(0), 4'b0000, CW'(0)})
            $display("FAIL reset_mid: got %h want %h", {address, valid, last, busy, done, wrap_cnt}, {AW'(0), 4'b0000, CW'(0)});
        else n_pass++;
        reset = 0; start = 0; abort = 0; op_done = 1;
        cycle();
        op_done = 0;
        n_checks++;
        if (busy !== 1'b0 || {address, valid, last, busy, done, wrap_cnt} !== exp_vec())
            $display("FAIL reset_mid_idle: got %h want %h", {address, valid, last, busy, done, wrap_cnt}, exp_vec());
        else n_pass++;
    endtask

    task automatic test_saturate();
        set_cfg(5, 2, 1, 0, 1);
        start = 1;
        cycle();
        start = 0; op_done = 1;
        for (int i = 0; i < 260; i++) begin
            n_checks++;
            if ({address, valid, last, busy, done, wrap_cnt} !== exp_vec())
                $display("FAIL saturate cyc%0d: got %h want %h", i, {address, valid, last, busy, done, wrap_cnt}, exp_vec());
            else n_pass++;
            cycle();
        end
        op_done = 0;
        n_checks++;
        if (address !== 3'd5 || !last || wrap_cnt !== 8'd255)
            $display("FAIL saturate_end: got addr=%0d last=%0b wc=%0d want addr=5 last=1 wc=255",
                     address, last, wrap_cnt);
        else n_pass++;
        abort = 1;
        cycle();
        abort = 0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            start = 1;
            for (int i = 0; i < 30; i++) begin
                cycle();
                n_checks++;
                if ({address, valid, last, busy, done, wrap_cnt} !== exp_vec())
                    $display("FAIL random t%0d cyc%0d: got %h want %h", t, i,
                             {address, valid, last, busy, done, wrap_cnt}, exp_vec());
                else n_pass++;
                op_done = ($urandom_range(0, 9) < 7);
                abort   = ($urandom_range(0, 99) < 3);
                reset   = ($urandom_range(0, 99) < 1);
                start   = ($urandom_range(0, 9) < 2);
                set_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            reset = 0; abort = 1; start = 0; op_done = 0;
            cycle();
            abort = 0;
        end
    endtask

    initial begin
        reset = 1; start = 0; abort = 0; op_done = 0;
        set_cfg(0, 0, 0, 0, 0);
        test_reset();
        test_up_oneshot();
        test_down_wrap();
        test_step_zero();
        test_abort();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/addr_seq_gen.md
# addr_seq_gen

Parametrised address sequencer that generates the operand/result address stream for the ALU datapath. It replaces the fixed 3-bit, fixed-order address generator with a programmable one. Each sequence is defined by a run-time base, limit, step, direction and wrap mode. It sits between the ALU controller (which issues `start` and `op_done`) and the register-file/memory address port.

## Interface
Parameters:
- `ADDR_W`, 3: address width in bits.
- `CNT_W`, 8: width of the wrap counter.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sequence; accepted only in IDLE.
- `abort`  in  1  terminate the current sequence; no `done` pulse.
- `op_done`  in  1  the operation on the current address has finished; advance.
- `cfg_base`  in  ADDR_W  first address of the sequence.
- `cfg_limit`  in  ADDR_W  final address bound.
- `cfg_step`  in  ADDR_W  increment magnitude; 0 is treated as 1.
- `cfg_down`  in  1  0 = count up, 1 = count down.
- `cfg_wrap`  in  1  1 = restart at base after the last address; 0 = one-shot.
- `address`  out  ADDR_W  current address.
- `valid`  out  1  `address` is live (RUN state).
- `last`  out  1  `address` is the final address of this pass.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse on completion of a one-shot sequence.
- `wrap_cnt`  out  CNT_W  number of wraps completed since `start`; saturates at all-ones.

## Operation
- FSM has three states: IDLE, RUN and DONE.
- **IDLE:** `valid`=0, `busy`=0, and `address` holds its last value. On `start`=1:
  - all `cfg_*` inputs are latched into internal registers;
  - `address` <= `cfg_base` and `wrap_cnt` <= 0;
  - state goes to RUN.
- `cfg_*` inputs are ignored outside the `start` cycle. Changing them mid-run has no effect.
- **RUN:** `valid`=1 and `busy`=1.
  - The remaining distance is computed in ADDR_W+1 bits:
    - up: `rem` = limit − address, forced to 0 if address > limit;
    - down: `rem` = address − limit, forced to 0 if address < limit.
  - `last` = (`rem` < effective step). It is combinational from the registered state.
  - On `op_done`=1 with `last`=0: `address` <= address ± step. No overflow is possible, because `rem` ≥ step.
  - On `op_done`=1 with `last`=1 and wrap=1: `address` <= base, `wrap_cnt` increments (saturating), and the FSM stays in RUN.
  - On `op_done`=1 with `last`=1 and wrap=0: state goes to DONE and `address` holds.
- **DONE:** lasts exactly one cycle. `done`=1, `valid`=0, `busy`=1, then the FSM returns to IDLE.
- **abort=1** in RUN or DONE sends the FSM to IDLE on the next edge.
  - `done` is not pulsed; if abort is taken in DONE, `done` still shows 1 in that cycle only.
  - abort has priority over `op_done`.
- **start** in RUN or DONE is ignored.
- **Base beyond limit** in the counting direction: `rem`=0, so `last`=1 immediately. This gives a single-address sequence, or a constant address with `wrap_cnt` counting when wrap=1.
- Reset values:
  - state IDLE, `address`=0, `valid`=0, `last`=0, `busy`=0, `done`=0, `wrap_cnt`=0;
  - internal cfg registers=0, with step treated as 1.
- `last` is forced to 0 when the state is not RUN.

## Timing
- `start` sampled at edge N: `address`=base and `valid`=1 from N (after the edge) onward.
- `op_done` sampled at edge M: the new `address` is visible after M. The latency is one cycle, with no bubble.
- `op_done` held high continuously advances the address once per cycle.
- After the final `op_done` of a one-shot sequence, `done`=1 for exactly one cycle. `start` is accepted from the following cycle, i.e. the first IDLE cycle.
- `reset` overrides everything, including mid-sequence and coincident `start`/`op_done`/`abort`. All outputs take their reset values after the edge.
- Outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.

## Test plan
- Reset for 2 cycles, then idle 5 cycles. Require `address`=0, `valid`=0, `busy`=0, `done`=0 and `wrap_cnt`=0 throughout.
- ADDR_W=3, up one-shot, base=1, limit=6, step=2, `op_done` held high. Require `address` = 1, 3, 5 on consecutive cycles, with `last` only at 5. Then one cycle of `done`=1, then IDLE with `address`=5.
- Down with wrap, base=6, limit=0, step=3, `op_done` every other cycle. Require the sequence 6, 3, 0, 6, 3, 0, 6, `wrap_cnt` 0→1→2, and `done` never asserted.
- ADDR_W=3, up one-shot, base=0, limit=7, step=0. Require a step of 1 (addresses 0..7), no wrap past 7, and `done` after 7.
- In RUN at address 3: assert `abort` and `op_done` together. Require IDLE next cycle, `address`=3, and no `done`. A `start` in the following cycle is accepted.
- Mid-sequence reset with `op_done`=1 and `start`=1 in the same cycle. Require all outputs at reset values after the edge and the FSM in IDLE. Also: with base=5, limit=2, up, wrap=1, require `address` constant at 5 with `last`=1, and `wrap_cnt` incrementing per `op_done` and saturating at 255.
